// File: rtl/arith_pkg.sv
// Shared arithmetic package: FSM state encodings and a count-width helper
// used by the sequential multiplier and divider.
package arith_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Bits needed to hold values 0..value-1
  function automatic int clog2(input int value);
    int bits;
    int v;
    bits = 0;
    v = value - 1;
    while (v > 0) begin
      bits = bits + 1;
      v = v >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference if it did not go negative.
module seq_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r,
  input  logic             d_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_next,
  output logic             qbit
);

  logic [WIDTH:0] t;

  // The trial value is W+1 bits wide so a shifted-out MSB still compares correctly
  always_comb begin
    t      = {r, d_bit};
    qbit   = (t >= {1'b0, divisor});
    r_next = qbit ? WIDTH'(t - {1'b0, divisor}) : t[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_unsigned_divider.sv
// Sequential restoring divider, one quotient bit per clock, start/ready handshake.
// Optional early overflow detection enabled by defining SEQ_DIV_OVF_CHECK_EN.
module seq_unsigned_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2*WIDTH-1:0]   ina,
  input  logic [WIDTH-1:0]     inb,
  input  logic                 start,
  output logic [WIDTH-1:0]     quot,
  output logic [WIDTH-1:0]     rem,
  output logic                 ovf,
  output logic                 ready
);

  localparam int CW = clog2(WIDTH + 1);

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-2:0] q_q;
  logic [WIDTH-1:0] inb_q;
  logic [WIDTH-1:0] r_next;
  logic             qbit;
  logic [WIDTH-1:0] q_next;

  seq_div_step #(.WIDTH(WIDTH)) u_step (
    .r       (r_q),
    .d_bit   (d_q[WIDTH-1]),
    .divisor (inb_q),
    .r_next  (r_next),
    .qbit    (qbit)
  );

  assign q_next = {q_q, qbit};

`ifdef SEQ_DIV_OVF_CHECK_EN
  logic ovf_cond;
  logic ovf_pend;
  assign ovf_cond = (ina[2*WIDTH-1:WIDTH] >= inb);
`else
  assign ovf = 1'b0;
`endif

  // An overflowing start still spends one cycle in RUN so it completes one edge later
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      r_q   <= '0;
      d_q   <= '0;
      q_q   <= '0;
      inb_q <= '0;
      quot  <= '0;
      rem   <= '0;
      ready <= 1'b0;
`ifdef SEQ_DIV_OVF_CHECK_EN
      ovf      <= 1'b0;
      ovf_pend <= 1'b0;
`endif
    end else if (start) begin
      state <= RUN;
      count <= CW'(WIDTH);
      r_q   <= ina[2*WIDTH-1:WIDTH];
      d_q   <= ina[WIDTH-1:0];
      q_q   <= '0;
      inb_q <= inb;
      ready <= 1'b0;
`ifdef SEQ_DIV_OVF_CHECK_EN
      ovf      <= 1'b0;
      ovf_pend <= ovf_cond;
`endif
    end else if (state == RUN) begin
`ifdef SEQ_DIV_OVF_CHECK_EN
      if (ovf_pend) begin
        state    <= DONE;
        count    <= '0;
        ready    <= 1'b1;
        ovf      <= 1'b1;
        ovf_pend <= 1'b0;
        quot     <= '1;
        rem      <= d_q;
      end else
`endif
      begin
        r_q   <= r_next;
        d_q   <= {d_q[WIDTH-2:0], 1'b0};
        q_q   <= q_next[WIDTH-2:0];
        count <= count - CW'(1);
        if (count == CW'(1)) begin
          state <= DONE;
          ready <= 1'b1;
          quot  <= q_next;
          rem   <= r_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_unsigned_divider.sv
// Self-checking bench for seq_unsigned_divider (WIDTH=8): directed table,
// restart/reset corner sequences and random non-overflow divides.
module tb_seq_unsigned_divider;

  logic        clk;
  logic        rst;
  logic [15:0] ina;
  logic [7:0]  inb;
  logic        start;
  logic [7:0]  quot;
  logic [7:0]  rem;
  logic        ovf;
  logic        ready;

  int n_vec;
  int n_miss;

  typedef struct {
    logic [15:0] ina;
    logic [7:0]  inb;
    logic [7:0]  quot;
    logic [7:0]  rem;
    logic        ovf;
    int          lat;
    bit          chk_val;
  } vec_t;

  vec_t vecs[8];

  seq_unsigned_divider #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .ina   (ina),
    .inb   (inb),
    .start (start),
    .quot  (quot),
    .rem   (rem),
    .ovf   (ovf),
    .ready (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_miss = n_miss + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] a, input logic [7:0] b);
    @(negedge clk);
    ina   = a;
    inb   = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after the start edge until ready; -1 if the budget expires
  task automatic wait_ready(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic idle_edges(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int lat;
    logic [7:0]  rb;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [15:0] ra;
    logic [15:0] exp_q;
    logic [15:0] exp_r;

    n_vec  = 0;
    n_miss = 0;
    rst    = 1'b1;
    start  = 1'b0;
    ina    = '0;
    inb    = '0;

    vecs[0] = '{16'd200,  8'd7,   8'd28,  8'd4,   1'b0, 8, 1'b1};
    vecs[1] = '{16'hFEFF, 8'hFF,  8'hFF,  8'hFE,  1'b0, 8, 1'b1};
    vecs[2] = '{16'd1000, 8'd37,  8'd27,  8'd1,   1'b0, 8, 1'b1};
    vecs[3] = '{16'h00FF, 8'h10,  8'h0F,  8'h0F,  1'b0, 8, 1'b1};
    vecs[4] = '{16'h0000, 8'd5,   8'd0,   8'd0,   1'b0, 8, 1'b1};
    vecs[5] = '{16'd100,  8'd9,   8'd11,  8'd1,   1'b0, 8, 1'b1};
`ifdef SEQ_DIV_OVF_CHECK_EN
    vecs[6] = '{16'h0100, 8'h01,  8'hFF,  8'h00,  1'b1, 1, 1'b1};
    vecs[7] = '{16'h1234, 8'h00,  8'hFF,  8'h34,  1'b1, 1, 1'b1};
`else
    vecs[6] = '{16'h0100, 8'h01,  8'h00,  8'h00,  1'b0, 8, 1'b0};
    vecs[7] = '{16'h1234, 8'h00,  8'h00,  8'h00,  1'b0, 8, 1'b0};
`endif

    idle_edges(2);
    check_output("reset_quot",  32'(quot),  32'd0);
    check_output("reset_rem",   32'(rem),   32'd0);
    check_output("reset_ovf",   32'(ovf),   32'd0);
    check_output("reset_ready", 32'(ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_edges(3);
    check_output("idle_ready", 32'(ready), 32'd0);

    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i].ina, vecs[i].inb);
      check_output($sformatf("v%0d_ready_clr", i), 32'(ready), 32'd0);
      wait_ready(lat);
      check_output($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check_output($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
      if (vecs[i].chk_val) begin
        check_output($sformatf("v%0d_quot", i), 32'(quot), 32'(vecs[i].quot));
        check_output($sformatf("v%0d_rem", i),  32'(rem),  32'(vecs[i].rem));
      end
      idle_edges(2);
      check_output($sformatf("v%0d_ready_hold", i), 32'(ready), 32'd1);
    end

    // Restart three cycles into a divide: only the second result may appear
    apply_stimulus(16'd200, 8'd7);
    idle_edges(2);
    apply_stimulus(16'd100, 8'd9);
    wait_ready(lat);
    check_output("restart_latency", 32'(lat), 32'd8);
    check_output("restart_quot", 32'(quot), 32'd11);
    check_output("restart_rem",  32'(rem),  32'd1);

    // Reset four edges into a divide
    apply_stimulus(16'd200, 8'd7);
    idle_edges(3);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_output("midrst_quot",  32'(quot),  32'd0);
    check_output("midrst_rem",   32'(rem),   32'd0);
    check_output("midrst_ovf",   32'(ovf),   32'd0);
    check_output("midrst_ready", 32'(ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_edges(12);
    check_output("midrst_idle_ready", 32'(ready), 32'd0);
    apply_stimulus(16'd50, 8'd5);
    wait_ready(lat);
    check_output("after_rst_latency", 32'(lat), 32'd8);
    check_output("after_rst_quot", 32'(quot), 32'd10);
    check_output("after_rst_rem",  32'(rem),  32'd0);

    // Reset and start on the same edge: reset wins, start is ignored
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    ina   = 16'd200;
    inb   = 8'd7;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    check_output("rst_start_ready", 32'(ready), 32'd0);
    check_output("rst_start_quot",  32'(quot),  32'd0);
    idle_edges(12);
    check_output("rst_start_idle_ready", 32'(ready), 32'd0);

    // Random divides with the high half below the divisor, against / and %
    for (int k = 0; k < 1000; k++) begin
      rb = 8'($urandom_range(1, 255));
      hi = 8'($urandom_range(0, 32'(rb) - 1));
      lo = 8'($urandom_range(0, 255));
      ra = {hi, lo};
      exp_q = ra / {8'd0, rb};
      exp_r = ra % {8'd0, rb};
      apply_stimulus(ra, rb);
      wait_ready(lat);
      check_output($sformatf("rand%0d_latency", k), 32'(lat), 32'd8);
      check_output($sformatf("rand%0d_qr_%0d_by_%0d", k, ra, rb),
                   {16'd0, quot, rem}, {16'd0, exp_q[7:0], exp_r[7:0]});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
